avalon_write_master: RTL and testbench

- Parametrised Avalon-MM write master; successor to the fixed 4-bit single-sequence writer.
- On a start command, it issues a run of COUNT writes: consecutive (strided) addresses, incrementing data pattern.
- It obeys waitrequest and signals completion.
- Used by the York Lava Avalon examples and test harnesses to drive memory/peripheral slaves with configurable width and length.

---
 rtl/avalon_write_master.sv | 135 +++++++++++++
 tb/tb_avalon_write_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_write_master.sv
// avalon_write_master: Avalon-MM write master that issues a run of `count`
// writes starting at base_address (advancing by STRIDE) with writedata
// starting at seed (advancing by 1).
//
// Optional feature, selected by the macro AVALON_WRITE_TIMEOUT_EN:
//   when defined, a stall counter aborts a run after TIMEOUT consecutive
//   stalled cycles and raises a sticky error flag.
//   when undefined, no counter exists and error is tied low.
//
// Handshake: a beat is presented with write=1 and is accepted on the first
// rising edge where waitrequest=0. While waitrequest=1 the address,
// writedata and write outputs hold stable. The next beat follows on the
// very next cycle (back-to-back).
module avalon_write_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int COUNT_W = 8,
  parameter int STRIDE  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_address,
  input  logic [COUNT_W-1:0] count,
  input  logic [DATA_W-1:0]  seed,
  input  logic               waitrequest,
  output logic               write,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  writedata,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [COUNT_W-1:0] remaining;

`ifdef AVALON_WRITE_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt;
`else
  assign error = 1'b0;
`endif

  // Control FSM with all Avalon and status outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      write     <= 1'b0;
      address   <= '0;
      writedata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef AVALON_WRITE_TIMEOUT_EN
      error     <= 1'b0;
      stall_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef AVALON_WRITE_TIMEOUT_EN
            error     <= 1'b0;
            stall_cnt <= '0;
`endif
            if (count != '0) begin
              state     <= S_WRITE;
              write     <= 1'b1;
              address   <= base_address;
              writedata <= seed;
              remaining <= count;
              busy      <= 1'b1;
            end else begin
              // Empty run: go straight to the completion pulse.
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (!waitrequest) begin
`ifdef AVALON_WRITE_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (remaining == COUNT_W'(1)) begin
              // Last beat accepted; address/writedata keep their last values.
              write     <= 1'b0;
              busy      <= 1'b0;
              remaining <= '0;
              state     <= S_DONE;
              done      <= 1'b1;
            end else begin
              address   <= address + ADDR_W'(STRIDE);
              writedata <= writedata + DATA_W'(1);
              remaining <= remaining - COUNT_W'(1);
            end
          end
`ifdef AVALON_WRITE_TIMEOUT_EN
          else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th consecutive stalled cycle: abort.
            write     <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
            error     <= 1'b1;
            stall_cnt <= '0;
            state     <= S_DONE;
            done      <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
`endif
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_write_master.sv
// Testbench for avalon_write_master: directed and randomized runs checked
// against a transaction-level model (expected address/data queue).
module tb_avalon_write_master;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 4;
  localparam int COUNT_W = 8;
  localparam int STRIDE  = 1;
  localparam int TIMEOUT = 16;
  localparam int AW      = ADDR_W + DATA_W;

  logic               clock;
  logic               reset;
  logic               start;
  logic [ADDR_W-1:0]  base_address;
  logic [COUNT_W-1:0] count;
  logic [DATA_W-1:0]  seed;
  logic               waitrequest;
  logic               write;
  logic [ADDR_W-1:0]  address;
  logic [DATA_W-1:0]  writedata;
  logic               busy;
  logic               done;
  logic               error;

  int n_checks = 0;
  int n_pass   = 0;

  avalon_write_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .COUNT_W(COUNT_W),
    .STRIDE (STRIDE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_address(base_address),
    .count       (count),
    .seed        (seed),
    .waitrequest (waitrequest),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One run: mode 0 = no stalls, 1 = stall/accept alternating, 2 = random.
  // poke pulses a foreign start mid-run and during the done cycle.
  task automatic do_run(input int base, input int cnt, input int sd,
                        input int mode, input bit poke);
    logic [AW-1:0]     exp_q[$];
    logic [AW-1:0]     front;
    logic [AW-1:0]     last;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              wr;
    logic              toggle;
    int                cyc;
    int                budget;

    exp_q = {};
    for (int i = 0; i < cnt; i++) begin
      ea = ADDR_W'((base + i * STRIDE) % (1 << ADDR_W));
      ed = DATA_W'((sd + i) % (1 << DATA_W));
      exp_q.push_back({ea, ed});
    end
    last = (cnt > 0) ? exp_q[cnt-1] : '0;

    start        = 1'b1;
    base_address = ADDR_W'(base);
    count        = COUNT_W'(cnt);
    seed         = DATA_W'(sd);
    tick();
    start = 1'b0;

    cyc    = 0;
    budget = 4 * cnt + 8;
    toggle = 1'b1;
    while (exp_q.size() > 0 && cyc < budget) begin
      front = exp_q[0];
      chk("write_active", write, 1);
      chk("busy_active", busy, 1);
      chk("done_low", done, 0);
      chk("address", address, front[AW-1:DATA_W]);
      chk("writedata", writedata, front[DATA_W-1:0]);
`ifndef AVALON_WRITE_TIMEOUT_EN
      chk("error_tied", error, 0);
`endif
      case (mode)
        0:       wr = 1'b0;
        1:       begin wr = toggle; toggle = ~toggle; end
        default: wr = 1'($urandom_range(0, 1));
      endcase
      waitrequest = wr;
      if (poke && cyc == 1) begin
        start        = 1'b1;
        base_address = ADDR_W'($urandom_range(0, 15));
        count        = COUNT_W'($urandom_range(1, 5));
        seed         = DATA_W'($urandom_range(0, 15));
      end
      tick();
      start       = 1'b0;
      waitrequest = 1'b0;
      if (!wr) void'(exp_q.pop_front());
      cyc++;
    end
    chk("run_complete", (exp_q.size() == 0), 1);
    if (mode == 0) chk("cycles_no_stall", cyc, cnt);
    if (mode == 1) chk("cycles_alternate", cyc, 2 * cnt);

    // Completion cycle
    chk("done_pulse", done, 1);
    chk("write_after_run", write, 0);
    chk("busy_in_done", busy, 0);
    if (cnt > 0) begin
      chk("address_hold", address, last[AW-1:DATA_W]);
      chk("writedata_hold", writedata, last[DATA_W-1:0]);
    end
    if (poke) begin
      start = 1'b1;
      count = COUNT_W'(1);
    end
    tick();
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("write_idle", write, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    count        = '0;
    seed         = '0;
    waitrequest  = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_write", write, 0);
    chk("rst_address", address, 0);
    chk("rst_writedata", writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    tick();

    // Basic run, then alternating stalls, then wrap-around
    do_run(3, 4, 5, 0, 1'b0);
    do_run(3, 4, 5, 1, 1'b0);
    do_run(14, 3, 15, 0, 1'b0);

    // Empty run and ignored starts
    do_run(7, 0, 2, 0, 1'b0);
    do_run(3, 4, 5, 0, 1'b1);

    // Reset during the second beat
    start        = 1'b1;
    base_address = ADDR_W'(3);
    count        = COUNT_W'(4);
    seed         = DATA_W'(5);
    tick();
    start = 1'b0;
    chk("mr_first_addr", address, 3);
    tick();
    chk("mr_second_addr", address, 4);
    chk("mr_second_data", writedata, 6);
    reset = 1'b1;
    tick();
    chk("mr_write", write, 0);
    chk("mr_busy", busy, 0);
    chk("mr_address", address, 0);
    chk("mr_writedata", writedata, 0);
    chk("mr_done", done, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_done", done, 0);
      chk("mr_no_write", write, 0);
    end

    // Reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    count = COUNT_W'(2);
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rs_write", write, 0);
    chk("rs_busy", busy, 0);
    tick();
    chk("rs_write_next", write, 0);
    chk("rs_done_next", done, 0);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      do_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
             int'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)));
    end

`ifdef AVALON_WRITE_TIMEOUT_EN
    // Permanent stall: abort after TIMEOUT stalled cycles
    start = 1'b1;
    base_address = ADDR_W'(1);
    count = COUNT_W'(4);
    seed = DATA_W'(2);
    tick();
    start = 1'b0;
    waitrequest = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_write_held", write, 1);
      chk("to_error_low", error, 0);
      tick();
    end
    chk("to_write_drop", write, 0);
    chk("to_done", done, 1);
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    waitrequest = 1'b0;
    tick();
    chk("to_error_sticky", error, 1);
    chk("to_done_low", done, 0);
    start = 1'b1;
    count = COUNT_W'(1);
    tick();
    start = 1'b0;
    chk("to_error_cleared", error, 0);
    chk("to_new_write", write, 1);
    tick();
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
